// File: rtl/ej32_lsq_if.sv
// Request and byte-wide memory bus bundle for the eJ32 load/store sequencer.
// slave = sequencer side, master = core/memory side.
interface ej32_lsq_if #(
    parameter int unsigned DSZ = 32,
    parameter int unsigned ASZ = 17
);
    logic           req;
    logic           rdy;
    logic           we;
    logic [1:0]     sz;
    logic           sx;
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] wdata;
    logic           done;
    logic           err;
    logic [DSZ-1:0] rdata;
    logic           mem_en;
    logic           mem_we;
    logic [ASZ-1:0] mem_addr;
    logic [7:0]     mem_wdata;
    logic [7:0]     mem_rdata;

    modport slave (
        input  req, we, sz, sx, addr, wdata, mem_rdata,
        output rdy, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, sz, sx, addr, wdata, mem_rdata,
        input  rdy, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ej32_lsq.sv
// eJ32 load/store sequencer: moves 1/2/4/8 bytes MSB first over a byte-wide memory bus.
// Define EJ32_LS_ALIGN_EN to reject accesses whose address is not a multiple of the size.
module ej32_lsq #(
    parameter int unsigned DSZ = 32,
    parameter int unsigned ASZ = 17
) (
    input logic       clk,
    input logic       rst,
    ej32_lsq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StXfer, StTail, StFin} state_e;

    // Bit shift that pushes an N-byte right-justified value to the top of the word.
    function automatic int unsigned fill_shift(logic [1:0] s);
        int unsigned nb;
        nb = 32'd8 << s;
        if (nb > DSZ) nb = DSZ;
        return DSZ - nb;
    endfunction

    state_e         state_q, state_d;
    logic [2:0]     i_q, i_d;
    logic           we_q, we_d;
    logic [1:0]     sz_q, sz_d;
    logic           sx_q, sx_d;
    logic [DSZ-1:0] wsh_q, wsh_d;
    logic [DSZ-1:0] acc_q, acc_d;
    logic [DSZ-1:0] rdata_q, rdata_d;
    logic           rdy_q, rdy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           mem_en_q, mem_en_d;
    logic           mem_we_q, mem_we_d;
    logic [ASZ-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]     mem_wdata_q, mem_wdata_d;

    logic           accept;
    logic           size_bad;
    logic           misaligned;
    logic           illegal;
    logic           last_beat;
    logic [DSZ-1:0] aligned;
    logic [DSZ-1:0] full;
    logic [DSZ-1:0] mask;
    logic [DSZ-1:0] sign_bit;

    assign accept   = bus.req && rdy_q;
    assign size_bad = (DSZ < 64) && (bus.sz == 2'd3);

`ifdef EJ32_LS_ALIGN_EN
    logic [2:0] req_low;
    assign req_low    = 3'((4'd1 << bus.sz) - 4'd1);
    assign misaligned = (bus.addr[2:0] & req_low) != 3'd0;
`else
    assign misaligned = 1'b0;
`endif

    assign illegal   = size_bad || misaligned;
    assign last_beat = (i_q == 3'((4'd1 << sz_q) - 4'd1));
    assign aligned   = bus.wdata << fill_shift(bus.sz);

    // Final load value: accumulated bytes plus the byte arriving in TAIL.
    assign full     = {acc_q[DSZ-9:0], bus.mem_rdata};
    assign mask     = {DSZ{1'b1}} >> fill_shift(sz_q);
    assign sign_bit = mask & ~(mask >> 1);

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        we_d        = we_q;
        sz_d        = sz_q;
        sx_d        = sx_q;
        wsh_d       = wsh_q;
        acc_d       = acc_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle, StFin: begin
                if (accept) begin
                    we_d  = bus.we;
                    sz_d  = bus.sz;
                    sx_d  = bus.sx;
                    i_d   = 3'd0;
                    acc_d = '0;
                    if (illegal) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = StXfer;
                        mem_en_d    = 1'b1;
                        mem_we_d    = bus.we;
                        mem_addr_d  = bus.addr;
                        mem_wdata_d = aligned[DSZ-1 -: 8];
                        wsh_d       = aligned << 8;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StXfer: begin
                // Read data lags its beat by one cycle, so beat 0 has nothing to collect yet.
                if (!we_q && i_q != 3'd0) acc_d = {acc_q[DSZ-9:0], bus.mem_rdata};
                if (last_beat) begin
                    state_d = we_q ? StFin : StTail;
                    done_d  = we_q;
                end else begin
                    i_d         = i_q + 3'd1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_q;
                    mem_addr_d  = mem_addr_q + 1'b1;
                    mem_wdata_d = wsh_q[DSZ-1 -: 8];
                    wsh_d       = wsh_q << 8;
                end
            end
            StTail: begin
                rdata_d = (full & mask) | ((sx_q && |(full & sign_bit)) ? ~mask : '0);
                state_d = StFin;
                done_d  = 1'b1;
            end
        endcase
    end

    assign rdy_d = (state_d == StIdle) || (state_d == StFin);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            i_q         <= 3'd0;
            we_q        <= 1'b0;
            sz_q        <= 2'd0;
            sx_q        <= 1'b0;
            wsh_q       <= '0;
            acc_q       <= '0;
            rdata_q     <= '0;
            rdy_q       <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            we_q        <= we_d;
            sz_q        <= sz_d;
            sx_q        <= sx_d;
            wsh_q       <= wsh_d;
            acc_q       <= acc_d;
            rdata_q     <= rdata_d;
            rdy_q       <= rdy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.rdy       = rdy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ej32_lsq.sv
// Randomised bench for ej32_lsq: a 32-bit and a 64-bit instance against a byte-array memory model.
module tb_ej32_lsq;

`ifdef EJ32_LS_ALIGN_EN
    localparam bit AlignEn = 1'b1;
`else
    localparam bit AlignEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ej32_lsq_if #(.DSZ(32), .ASZ(17)) b32 ();
    ej32_lsq_if #(.DSZ(64), .ASZ(17)) b64 ();

    ej32_lsq #(.DSZ(32), .ASZ(17)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
    ej32_lsq #(.DSZ(64), .ASZ(17)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

    bit [7:0] smem32 [0:131071];
    bit [7:0] smem64 [0:131071];
    bit [7:0] ref32  [0:131071];
    bit [7:0] ref64  [0:131071];
    logic [7:0] rd32 = 8'h00;
    logic [7:0] rd64 = 8'h00;
    assign b32.mem_rdata = rd32;
    assign b64.mem_rdata = rd64;

    always @(posedge clk) begin
        if (b32.mem_en) begin
            if (b32.mem_we) smem32[b32.mem_addr] <= b32.mem_wdata;
            rd32 <= smem32[b32.mem_addr];
        end
        if (b64.mem_en) begin
            if (b64.mem_we) smem64[b64.mem_addr] <= b64.mem_wdata;
            rd64 <= smem64[b64.mem_addr];
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] last_rd [2];
    bit          nx_we;
    logic [1:0]  nx_sz;
    bit          nx_sx;
    logic [16:0] nx_addr;
    logic [63:0] nx_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rref(input bit w64, input logic [16:0] a);
        return w64 ? ref64[a] : ref32[a];
    endfunction

    function automatic logic [7:0] rsim(input bit w64, input logic [16:0] a);
        return w64 ? smem64[a] : smem32[a];
    endfunction

    task automatic wref(input bit w64, input logic [16:0] a, input logic [7:0] v);
        if (w64) ref64[a] = v;
        else ref32[a] = v;
    endtask

    // Big-endian fetch of n bytes, then zero/sign extension to the data width.
    function automatic logic [63:0] model_load(input bit w64, input int n, input bit sx,
                                               input logic [16:0] a);
        logic [63:0] v;
        int nb;
        v  = 64'd0;
        nb = 8 * n;
        for (int j = 0; j < n; j++) v = (v << 8) | 64'(rref(w64, 17'(a + 17'(j))));
        if (sx && nb < (w64 ? 64 : 32) && ((v >> (nb - 1)) & 64'd1) != 64'd0)
            v = v | ~((64'd1 << nb) - 64'd1);
        if (!w64) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic drv(input bit w64, input bit req, input bit we, input logic [1:0] sz,
                       input bit sx, input logic [16:0] addr, input logic [63:0] wd);
        if (w64) begin
            b64.req = req; b64.we = we; b64.sz = sz; b64.sx = sx; b64.addr = addr;
            b64.wdata = wd;
        end else begin
            b32.req = req; b32.we = we; b32.sz = sz; b32.sx = sx; b32.addr = addr;
            b32.wdata = wd[31:0];
        end
    endtask

    task automatic drv_req(input bit w64, input bit v);
        if (w64) b64.req = v;
        else b32.req = v;
    endtask

    task automatic smp(input bit w64, output logic en, output logic mwe, output logic [16:0] ma,
                       output logic [7:0] mw, output logic dn, output logic er, output logic ry,
                       output logic [63:0] rd);
        if (w64) begin
            en = b64.mem_en; mwe = b64.mem_we; ma = b64.mem_addr; mw = b64.mem_wdata;
            dn = b64.done; er = b64.err; ry = b64.rdy; rd = b64.rdata;
        end else begin
            en = b32.mem_en; mwe = b32.mem_we; ma = b32.mem_addr; mw = b32.mem_wdata;
            dn = b32.done; er = b32.err; ry = b32.rdy; rd = {32'h0, b32.rdata};
        end
    endtask

    // One transaction; with pre=1 the request is already on the bus (issued in the FIN cycle).
    task automatic do_op(input bit w64, input bit we, input logic [1:0] sz, input bit sx,
                         input logic [16:0] addr, input logic [63:0] wdata, input bit pre,
                         input bit chain, output logic [63:0] got_rd, output logic got_err);
        int n, lat;
        bit illegal, seen;
        logic en, mwe, dn, er, ry;
        logic [16:0] ma;
        logic [7:0] mw, bexp;
        logic [63:0] rd;
        int bcyc[$];
        logic [16:0] badr[$];
        logic bwe[$];
        logic [7:0] bwd[$];
        n       = 1 << sz;
        illegal = (sz == 2'd3 && !w64) || (AlignEn && (int'(addr) % n) != 0);
        seen    = 1'b0;
        lat     = 0;
        got_rd  = 64'd0;
        got_err = 1'b0;
        if (!pre) begin
            @(negedge clk);
            drv(w64, 1'b1, we, sz, sx, addr, wdata);
        end
        smp(w64, en, mwe, ma, mw, dn, er, ry, rd);
        chk("rdy_at_req", 64'(ry), 64'd1);
        @(posedge clk);
        #1 drv_req(w64, 1'b0);
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            smp(w64, en, mwe, ma, mw, dn, er, ry, rd);
            if (en) begin
                bcyc.push_back(c); badr.push_back(ma); bwe.push_back(mwe); bwd.push_back(mw);
            end
            if (dn) begin
                seen = 1'b1; lat = c; got_err = er; got_rd = rd;
                if (chain) drv(w64, 1'b1, nx_we, nx_sz, nx_sx, nx_addr, nx_wdata);
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(lat), 64'(illegal ? 1 : (we ? n + 1 : n + 2)));
        chk("err", 64'(got_err), 64'(illegal));
        chk("beat_count", 64'(bcyc.size()), 64'(illegal ? 0 : n));
        foreach (bcyc[j]) begin
            chk("beat_cycle", 64'(bcyc[j]), 64'(j + 1));
            chk("beat_addr", 64'(badr[j]), 64'(17'(addr + 17'(j))));
            chk("beat_we", 64'(bwe[j]), 64'(we));
            if (we) begin
                bexp = 8'(wdata >> (8 * (n - 1 - j)));
                chk("beat_wdata", 64'(bwd[j]), 64'(bexp));
            end
        end
        if (!illegal && we) begin
            for (int j = 0; j < n; j++) begin
                wref(w64, 17'(addr + 17'(j)), 8'(wdata >> (8 * (n - 1 - j))));
                chk("mem_byte", 64'(rsim(w64, 17'(addr + 17'(j)))),
                    64'(rref(w64, 17'(addr + 17'(j)))));
            end
        end
        if (!illegal && !we) last_rd[w64] = model_load(w64, n, sx, addr);
        chk("rdata", got_rd, last_rd[w64]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic e, en, mwe, dn, er, ry;
        logic [16:0] ma;
        logic [7:0] mw;
        logic [63:0] rd;
        int dcnt, ops;
        bit cw64, cwe, csx, pre, ch;
        logic [1:0] csz;
        logic [16:0] caddr;
        logic [63:0] cwd;

        last_rd[0] = 64'd0;
        last_rd[1] = 64'd0;
        drv(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 17'd0, 64'd0);
        drv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 17'd0, 64'd0);
        #1 rst = 1'b0;
        #2;
        for (int w = 0; w < 2; w++) begin
            smp(w[0], en, mwe, ma, mw, dn, er, ry, rd);
            chk("reset_rdy", 64'(ry), 64'd1);
            chk("reset_done", 64'(dn), 64'd0);
            chk("reset_err", 64'(er), 64'd0);
            chk("reset_rdata", rd, 64'd0);
            chk("reset_mem_en", 64'(en), 64'd0);
            chk("reset_mem_we", 64'(mwe), 64'd0);
            chk("reset_mem_addr", 64'(ma), 64'd0);
            chk("reset_mem_wdata", 64'(mw), 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 4-byte store then load back.
        do_op(1'b0, 1'b1, 2'd2, 1'b0, 17'h00100, 64'h12345678, 1'b0, 1'b0, r, e);
        do_op(1'b0, 1'b0, 2'd2, 1'b0, 17'h00100, 64'd0, 1'b0, 1'b0, r, e);
        chk("ld4_value", r, 64'h12345678);

        // Sign and zero extension of a single byte.
        do_op(1'b0, 1'b1, 2'd0, 1'b0, 17'h00200, 64'h80, 1'b0, 1'b0, r, e);
        do_op(1'b0, 1'b0, 2'd0, 1'b1, 17'h00200, 64'd0, 1'b0, 1'b0, r, e);
        chk("ld1_sx", r, 64'hFFFFFF80);
        do_op(1'b0, 1'b0, 2'd0, 1'b0, 17'h00200, 64'd0, 1'b0, 1'b0, r, e);
        chk("ld1_zx", r, 64'h00000080);

        // 2-byte store wrapping past the top of the address space.
        do_op(1'b0, 1'b1, 2'd1, 1'b0, 17'h1FFFF, 64'hABCD, 1'b0, 1'b0, r, e);
        chk("wrap_hi", 64'(smem32[17'h1FFFF]), 64'hAB);
        chk("wrap_lo", 64'(smem32[17'h00000]), 64'hCD);

        // Misaligned 4-byte load and an 8-byte request on the 32-bit instance.
        do_op(1'b0, 1'b0, 2'd2, 1'b0, 17'h00101, 64'd0, 1'b0, 1'b0, r, e);
        chk("align_err", 64'(e), 64'(AlignEn));
        do_op(1'b0, 1'b0, 2'd3, 1'b0, 17'h00100, 64'd0, 1'b0, 1'b0, r, e);
        chk("sz3_err32", 64'(e), 64'd1);

        // 8-byte store followed in its FIN cycle by an 8-byte load.
        nx_we = 1'b0; nx_sz = 2'd3; nx_sx = 1'b0; nx_addr = 17'h00300; nx_wdata = 64'd0;
        do_op(1'b1, 1'b1, 2'd3, 1'b0, 17'h00300, 64'h0123456789ABCDEF, 1'b0, 1'b1, r, e);
        do_op(1'b1, 1'b0, 2'd3, 1'b1, 17'h00300, 64'd0, 1'b1, 1'b0, r, e);
        chk("b2b_ld8", r, 64'h0123456789ABCDEF);

        // Reset during beat 2 of a 4-byte store.
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 17'h00040, 64'hA1B2C3D4);
        @(posedge clk);
        #1 drv_req(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        smp(1'b0, en, mwe, ma, mw, dn, er, ry, rd);
        chk("rst_pre_addr", 64'(ma), 64'h42);
        chk("rst_pre_we", 64'(mwe), 64'd1);
        rst = 1'b0;
        #1;
        smp(1'b0, en, mwe, ma, mw, dn, er, ry, rd);
        chk("rst_mem_en", 64'(en), 64'd0);
        chk("rst_mem_we", 64'(mwe), 64'd0);
        chk("rst_rdy", 64'(ry), 64'd1);
        chk("rst_rdata", rd, 64'd0);
        wref(1'b0, 17'h00040, 8'hA1);
        wref(1'b0, 17'h00041, 8'hB2);
        last_rd[0] = 64'd0;
        last_rd[1] = 64'd0;
        @(negedge clk);
        rst = 1'b1;
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            smp(1'b0, en, mwe, ma, mw, dn, er, ry, rd);
            if (dn) dcnt++;
        end
        chk("rst_stray_done", 64'(dcnt), 64'd0);
        for (int a = 'h40; a < 'h44; a++)
            chk("rst_partial_mem", 64'(smem32[a]), 64'(ref32[a]));
        do_op(1'b0, 1'b0, 2'd2, 1'b0, 17'h00040, 64'd0, 1'b0, 1'b0, r, e);
        chk("rst_then_load", r, 64'hA1B20000);

        // Random traffic, with occasional back-to-back requests.
        ops = 0;
        pre = 1'b0;
        cw64 = 1'b0; cwe = 1'b0; csx = 1'b0; csz = 2'd0; caddr = 17'd0; cwd = 64'd0;
        while (ops < 80 || pre) begin
            if (!pre) begin
                cw64 = 1'($urandom); cwe = 1'($urandom); csx = 1'($urandom);
                csz = 2'($urandom);
                caddr = 17'($urandom_range(0, 127));
                if ($urandom_range(0, 3) == 0) caddr = 17'h1FFF8 + 17'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 0) caddr = caddr & ~17'((1 << csz) - 1);
                cwd = {$urandom, $urandom};
            end
            ch = (ops < 79) && ($urandom_range(0, 3) == 0);
            if (ch) begin
                nx_we = 1'($urandom); nx_sx = 1'($urandom); nx_sz = 2'($urandom);
                nx_addr = $urandom_range(0, 1) == 0 ? caddr : 17'($urandom_range(0, 127));
                nx_wdata = {$urandom, $urandom};
            end
            do_op(cw64, cwe, csz, csx, caddr, cwd, pre, ch, r, e);
            ops++;
            pre = ch;
            if (ch) begin
                cwe = nx_we; csz = nx_sz; csx = nx_sx; caddr = nx_addr; cwd = nx_wdata;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
